// File: rtl/simon_playback.sv
// rtl/simon_playback.sv - Simon sequence playback engine: walks the sequence ROM and flashes each colour on the LEDs.
// Optional echo of player presses on the LEDs is enabled by defining PLAYBACK_ECHO_EN.
module simon_playback #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1
) (
    input  logic              slow_clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [1:0]        rd_data_i,
    input  logic              btn_valid_i,
    input  logic [1:0]        btn_val_i,
    output logic [3:0]        led_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH);

`ifdef PLAYBACK_ECHO_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ON    = 3'd3,
        S_OFF   = 3'd4,
        S_DONE  = 3'd5,
        S_ECHO  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ON    = 3'd3,
        S_OFF   = 3'd4,
        S_DONE  = 3'd5
    } state_t;
    wire unused_btn = ^{btn_valid_i, btn_val_i};
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [1:0]        sym_q, sym_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] len_clamp;

    // Clamping at capture keeps idx within the ROM's DEPTH entries.
    assign len_clamp = (len_i > DEPTH_L) ? DEPTH_L : len_i;

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            sym_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            sym_q   <= sym_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        sym_d   = sym_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    len_d   = len_clamp;
                    idx_d   = '0;
                    state_d = (len_clamp == '0) ? S_DONE : S_FETCH;
                end
`ifdef PLAYBACK_ECHO_EN
                else if (btn_valid_i && !abort_i) begin
                    sym_d   = btn_val_i;
                    tcnt_d  = '0;
                    state_d = S_ECHO;
                end
`endif
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                sym_d   = rd_data_i;
                tcnt_d  = '0;
                state_d = S_ON;
            end
            S_ON: begin
                if (tcnt_q == ON_LAST) begin
                    tcnt_d  = '0;
                    state_d = S_OFF;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_OFF: begin
                if (tcnt_q == OFF_LAST) begin
                    tcnt_d = '0;
                    if (idx_q == len_q - ADDR_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
`ifdef PLAYBACK_ECHO_EN
            S_ECHO: begin
                if (tcnt_q == ON_LAST) begin
                    tcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        led_o = 4'b0000;
`ifdef PLAYBACK_ECHO_EN
        if (state_q == S_ON || state_q == S_ECHO) led_o = 4'b0001 << sym_q;
`else
        if (state_q == S_ON) led_o = 4'b0001 << sym_q;
`endif
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign rd_addr_o = idx_q;

endmodule
